rdbk_frame_ctl: RTL and testbench

//  Parametrised configuration-readback engine, successor to the fixed single-bit readback cell.
//  On a user request it fetches FRAME_WORDS words from the config-memory read port and

---
 rtl/rdbk_frame_ctl.sv | 154 +++++++++++++++
 tb/tb_rdbk_frame_ctl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdbk_frame_ctl.sv
// Configuration readback engine: fetches FRAME_WORDS words from config memory and
// serialises them one bit per valid/ready transfer, optionally followed by a CRC-16.
module rdbk_frame_ctl #(
  parameter string FF_RDCFG    = "ENABLED",
  parameter int    DATA_WIDTH  = 32,
  parameter int    ADDR_WIDTH  = 12,
  parameter int    FRAME_WORDS = 16,
  parameter string BIT_ORDER   = "MSB",
  parameter bit    CRC_EN      = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RDCFGN,
  input  logic                  FFRDCFG,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
  output logic                  MEM_RE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA,
  output logic                  RDDATA,
  output logic                  RDVALID,
  input  logic                  RDREADY,
  output logic                  RDSOF,
  output logic                  RDEOF,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam bit REQ_EN    = (FF_RDCFG == "ENABLED");
  localparam bit MSB_FIRST = (BIT_ORDER == "MSB");
  localparam int BW        = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0]         LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_WORDS - 1);
  localparam logic [15:0]           CRC_POLY = 16'h1021;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    CRC   = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t                  state, state_nxt;
  logic                    rdcfgn_q;
  logic [ADDR_WIDTH-1:0]   base, idx;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [BW-1:0]           bitcnt;
  logic [15:0]             crc;
  logic [3:0]              crccnt;
  logic                    start, busy_st, abort, xfer, cur_bit, last_bit, last_word;
  logic [15:0]             crc_nxt;

  assign busy_st   = (state == FETCH) || (state == LOAD) || (state == SHIFT) || (state == CRC);
  assign start     = REQ_EN && rdcfgn_q && !RDCFGN && FFRDCFG;
  // Releasing the request mid-frame wins over a transfer in the same cycle.
  assign abort     = busy_st && RDCFGN;
  assign xfer      = RDVALID && RDREADY && !abort;
  assign cur_bit   = MSB_FIRST ? shreg[DATA_WIDTH-1] : shreg[0];
  assign last_bit  = (bitcnt == LAST_BIT);
  assign last_word = (idx == LAST_IDX);
  assign crc_nxt   = {crc[14:0], 1'b0} ^ ((crc[15] ^ cur_bit) ? CRC_POLY : 16'h0000);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (xfer && last_bit) state_nxt = !last_word ? FETCH : (CRC_EN ? CRC : FIN);
      CRC:     if (xfer && crccnt == 4'hF) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdcfgn_q <= 1'b1;
      base     <= '0;
      idx      <= '0;
      shreg    <= '0;
      bitcnt   <= '0;
      crc      <= '0;
      crccnt   <= '0;
    end else begin
      rdcfgn_q <= RDCFGN;
      case (state)
        IDLE: if (start) begin
          base <= BASE_ADDR;
          idx  <= '0;
          crc  <= 16'hFFFF;
        end
        LOAD: begin
          shreg  <= MEM_RDATA;
          bitcnt <= '0;
          crccnt <= '0;
        end
        SHIFT: if (xfer) begin
          shreg  <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
          bitcnt <= bitcnt + 1'b1;
          crc    <= crc_nxt;
          if (last_bit && !last_word) idx <= idx + 1'b1;
        end
        // CRC bits leave MSB first and are not folded back into the register.
        CRC: if (xfer) begin
          crc    <= {crc[14:0], 1'b0};
          crccnt <= crccnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    MEM_RE   = 1'b0;
    MEM_ADDR = base + idx;
    RDDATA   = 1'b0;
    RDVALID  = 1'b0;
    RDSOF    = 1'b0;
    RDEOF    = 1'b0;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    case (state)
      FETCH: begin
        MEM_RE = 1'b1;
        BUSY   = 1'b1;
      end
      LOAD: BUSY = 1'b1;
      SHIFT: begin
        BUSY    = 1'b1;
        RDVALID = 1'b1;
        RDDATA  = cur_bit;
        RDSOF   = (idx == '0) && (bitcnt == '0);
        RDEOF   = !CRC_EN && last_word && last_bit;
      end
      CRC: begin
        BUSY    = 1'b1;
        RDVALID = 1'b1;
        RDDATA  = crc[15];
        RDEOF   = (crccnt == 4'hF);
      end
      FIN: DONE = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rdbk_frame_ctl.sv
// Bench for rdbk_frame_ctl: four parameter variants share stimulus; streams are compared
// against a frame-level model and a table of hand-derived bitstreams.
module tb_rdbk_frame_ctl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NI = 4;
  localparam int CAPN = 8192;
  // Instance variants: 0 MSB/noCRC/2w, 1 LSB/CRC/2w, 2 MSB/CRC/1w, 3 disabled
  localparam logic [NI-1:0] I_MSB = 4'b1101;
  localparam logic [NI-1:0] I_CRC = 4'b0110;
  localparam logic [NI-1:0] I_EN  = 4'b0111;

  logic          CLK = 1'b0;
  logic          RST, RDCFGN, FFRDCFG, RDREADY;
  logic [AW-1:0] BASE_ADDR;
  logic          re [NI];
  logic [AW-1:0] maddr [NI];
  logic [DW-1:0] rdat [NI];
  logic          dat [NI], vld [NI], sof [NI], eof [NI], busy [NI], done [NI];
  logic [DW-1:0] mem [16];

  always #5 CLK = ~CLK;

  rdbk_frame_ctl #(.FF_RDCFG("ENABLED"), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_WORDS(2),
    .BIT_ORDER("MSB"), .CRC_EN(1'b0)) u_a (
    .CLK(CLK), .RST(RST), .RDCFGN(RDCFGN), .FFRDCFG(FFRDCFG), .BASE_ADDR(BASE_ADDR),
    .MEM_RE(re[0]), .MEM_ADDR(maddr[0]), .MEM_RDATA(rdat[0]), .RDDATA(dat[0]), .RDVALID(vld[0]),
    .RDREADY(RDREADY), .RDSOF(sof[0]), .RDEOF(eof[0]), .BUSY(busy[0]), .DONE(done[0]));
  rdbk_frame_ctl #(.FF_RDCFG("ENABLED"), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_WORDS(2),
    .BIT_ORDER("LSB"), .CRC_EN(1'b1)) u_b (
    .CLK(CLK), .RST(RST), .RDCFGN(RDCFGN), .FFRDCFG(FFRDCFG), .BASE_ADDR(BASE_ADDR),
    .MEM_RE(re[1]), .MEM_ADDR(maddr[1]), .MEM_RDATA(rdat[1]), .RDDATA(dat[1]), .RDVALID(vld[1]),
    .RDREADY(RDREADY), .RDSOF(sof[1]), .RDEOF(eof[1]), .BUSY(busy[1]), .DONE(done[1]));
  rdbk_frame_ctl #(.FF_RDCFG("ENABLED"), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_WORDS(1),
    .BIT_ORDER("MSB"), .CRC_EN(1'b1)) u_c (
    .CLK(CLK), .RST(RST), .RDCFGN(RDCFGN), .FFRDCFG(FFRDCFG), .BASE_ADDR(BASE_ADDR),
    .MEM_RE(re[2]), .MEM_ADDR(maddr[2]), .MEM_RDATA(rdat[2]), .RDDATA(dat[2]), .RDVALID(vld[2]),
    .RDREADY(RDREADY), .RDSOF(sof[2]), .RDEOF(eof[2]), .BUSY(busy[2]), .DONE(done[2]));
  rdbk_frame_ctl #(.FF_RDCFG("DISABLED"), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_WORDS(2),
    .BIT_ORDER("MSB"), .CRC_EN(1'b0)) u_d (
    .CLK(CLK), .RST(RST), .RDCFGN(RDCFGN), .FFRDCFG(FFRDCFG), .BASE_ADDR(BASE_ADDR),
    .MEM_RE(re[3]), .MEM_ADDR(maddr[3]), .MEM_RDATA(rdat[3]), .RDDATA(dat[3]), .RDVALID(vld[3]),
    .RDREADY(RDREADY), .RDSOF(sof[3]), .RDEOF(eof[3]), .BUSY(busy[3]), .DONE(done[3]));

  // Memory read port: data valid only in the cycle after the strobe, junk otherwise.
  always @(posedge CLK)
    for (int i = 0; i < NI; i++)
      rdat[i] <= re[i] ? mem[maddr[i]] : DW'($urandom);

  // Sink-side monitor
  bit            cap_bit [NI][CAPN];
  bit            cap_sof [NI][CAPN];
  bit            cap_eof [NI][CAPN];
  logic [AW-1:0] cap_addr [NI][512];
  int            cap_n [NI], addr_n [NI], done_n [NI], stall_err [NI];
  bit            pst [NI], pdat [NI], psof [NI], peof [NI];

  always @(negedge CLK)
    for (int i = 0; i < NI; i++) begin
      if (pst[i] && vld[i] && (dat[i] !== pdat[i] || sof[i] !== psof[i] || eof[i] !== peof[i]))
        stall_err[i] <= stall_err[i] + 1;
      if (vld[i] && RDREADY) begin
        if (cap_n[i] < CAPN) begin
          cap_bit[i][cap_n[i]] <= dat[i];
          cap_sof[i][cap_n[i]] <= sof[i];
          cap_eof[i][cap_n[i]] <= eof[i];
        end
        cap_n[i] <= cap_n[i] + 1;
      end
      if (re[i]) begin
        if (addr_n[i] < 512) cap_addr[i][addr_n[i]] <= maddr[i];
        addr_n[i] <= addr_n[i] + 1;
      end
      if (done[i]) done_n[i] <= done_n[i] + 1;
      pst[i]  <= vld[i] && !RDREADY;
      pdat[i] <= dat[i];
      psof[i] <= sof[i];
      peof[i] <= eof[i];
    end

  int ready_mode, ready_pct;
  initial begin
    int rcyc;
    rcyc = 0;
    RDREADY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0:       RDREADY = 1'b1;
        1:       RDREADY = (rcyc % 3 == 0);
        default: RDREADY = ($urandom_range(0, 99) < ready_pct);
      endcase
      rcyc++;
    end
  end

  int checks, errors;
  int st_cap [NI], st_addr [NI], st_done [NI], st_stall [NI];
  bit            exp_bit [64];
  int            exp_n;
  logic [AW-1:0] exp_addr [2];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic snapshot();
    for (int i = 0; i < NI; i++) begin
      st_cap[i] = cap_n[i]; st_addr[i] = addr_n[i];
      st_done[i] = done_n[i]; st_stall[i] = stall_err[i];
    end
  endtask

  // Frame model: words in address order, bits in instance order, CCITT CRC over sent data bits.
  task automatic model(input int i, input logic [AW-1:0] base);
    logic [15:0] c;
    logic [DW-1:0] w;
    bit b, fb;
    int fw;
    fw = (i == 2) ? 1 : 2;
    exp_n = 0;
    c = 16'hFFFF;
    for (int wi = 0; wi < fw; wi++) begin
      exp_addr[wi] = AW'(int'(base) + wi);
      w = mem[exp_addr[wi]];
      for (int k = 0; k < DW; k++) begin
        b = I_MSB[i] ? w[DW-1-k] : w[k];
        exp_bit[exp_n] = b;
        exp_n++;
        fb = c[15] ^ b;
        c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    if (I_CRC[i])
      for (int k = 15; k >= 0; k--) begin
        exp_bit[exp_n] = c[k];
        exp_n++;
      end
  endtask

  task automatic check_frame(input string tag, input logic [AW-1:0] base);
    for (int i = 0; i < NI; i++) begin
      int n, bad, fw;
      n = cap_n[i] - st_cap[i];
      if (!I_EN[i]) begin
        chk($sformatf("%s i%0d ignored bits", tag, i), n, 0);
        chk($sformatf("%s i%0d ignored done", tag, i), done_n[i] - st_done[i], 0);
        continue;
      end
      model(i, base);
      fw = (i == 2) ? 1 : 2;
      chk($sformatf("%s i%0d length", tag, i), n, exp_n);
      bad = 0;
      for (int k = 0; k < n && k < exp_n; k++)
        if (cap_bit[i][st_cap[i]+k] != exp_bit[k]) bad++;
      chk($sformatf("%s i%0d bit errors", tag, i), bad, 0);
      bad = 0;
      for (int k = 0; k < n; k++)
        if (cap_sof[i][st_cap[i]+k] != (k == 0)) bad++;
      chk($sformatf("%s i%0d sof misplaced", tag, i), bad, 0);
      bad = 0;
      for (int k = 0; k < n; k++)
        if (cap_eof[i][st_cap[i]+k] != (k == exp_n - 1)) bad++;
      chk($sformatf("%s i%0d eof misplaced", tag, i), bad, 0);
      chk($sformatf("%s i%0d done pulses", tag, i), done_n[i] - st_done[i], 1);
      chk($sformatf("%s i%0d fetches", tag, i), addr_n[i] - st_addr[i], fw);
      bad = 0;
      for (int k = 0; k < fw && k < addr_n[i] - st_addr[i]; k++)
        if (cap_addr[i][st_addr[i]+k] !== exp_addr[k]) bad++;
      chk($sformatf("%s i%0d address errors", tag, i), bad, 0);
      chk($sformatf("%s i%0d stall instability", tag, i), stall_err[i] - st_stall[i], 0);
    end
  endtask

  task automatic run_frame(input string tag, input logic [AW-1:0] base, input int rmode,
                           input bit drop_ff);
    int n;
    ready_mode = rmode;
    snapshot();
    BASE_ADDR = base;
    RDCFGN = 1'b0;
    cyc(1);
    BASE_ADDR = AW'($urandom);
    if (drop_ff) FFRDCFG = 1'b0;
    n = 0;
    while (!((done_n[0] > st_done[0]) && (done_n[1] > st_done[1]) && (done_n[2] > st_done[2]))
           && n < 600) begin
      cyc(1);
      n++;
    end
    chk($sformatf("%s completed in time", tag), int'(n < 600), 1);
    cyc(4);
    RDCFGN = 1'b1;
    FFRDCFG = 1'b1;
    cyc(2);
    check_frame(tag, base);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [DW-1:0] w0, w1;
    int            rmode;
    logic [15:0]   exp_a;
    logic [15:0]   exp_b;
    logic [23:0]   exp_c;
  } vec_t;

  initial begin
    vec_t vt [4];
    logic [23:0] v;
    int n;
    vt[0] = '{4'h0, 8'hA5, 8'h3C, 0, 16'hA53C, 16'hA53C, 24'hA504BF};
    vt[1] = '{4'h3, 8'h00, 8'hFF, 0, 16'h00FF, 16'h00FF, 24'h00E1F0};
    vt[2] = '{4'hF, 8'hFF, 8'h01, 0, 16'hFF01, 16'hFF80, 24'hFFFF00};
    vt[3] = '{4'h5, 8'hA5, 8'h3C, 1, 16'hA53C, 16'hA53C, 24'hA504BF};
    checks = 0;
    errors = 0;
    ready_mode = 0;
    ready_pct = 100;
    RST = 1'b1;
    RDCFGN = 1'b1;
    FFRDCFG = 1'b1;
    BASE_ADDR = '0;
    for (int a = 0; a < 16; a++) mem[a] = '0;

    cyc(3);
    for (int i = 0; i < NI; i++)
      chk($sformatf("reset outputs i%0d", i),
          int'({re[i], maddr[i], dat[i], vld[i], sof[i], eof[i], busy[i], done[i]}), 0);

    // History register resets to 1: request held low through reset starts a frame.
    RDCFGN = 1'b0;
    RST = 1'b0;
    cyc(1);
    chk("start after reset release busy", int'(busy[0]), 1);
    chk("disabled variant stays idle", int'(busy[3]), 0);
    RDCFGN = 1'b1;
    cyc(3);
    chk("abort after reset start busy", int'(busy[0]), 0);

    foreach (vt[t]) begin
      mem[vt[t].base] = vt[t].w0;
      mem[AW'(int'(vt[t].base) + 1)] = vt[t].w1;
      run_frame($sformatf("vec%0d", t), vt[t].base, vt[t].rmode, 1'b0);
      v = '0;
      for (int k = 0; k < 16; k++) v = {v[22:0], cap_bit[0][st_cap[0]+k]};
      chk($sformatf("vec%0d stream A", t), int'(v[15:0]), int'(vt[t].exp_a));
      v = '0;
      for (int k = 0; k < 16; k++) v = {v[22:0], cap_bit[1][st_cap[1]+k]};
      chk($sformatf("vec%0d stream B data", t), int'(v[15:0]), int'(vt[t].exp_b));
      v = '0;
      for (int k = 0; k < 24; k++) v = {v[22:0], cap_bit[2][st_cap[2]+k]};
      chk($sformatf("vec%0d stream C", t), int'(v), int'(vt[t].exp_c));
    end

    // Requests with FFRDCFG low are ignored; raising it later without a new edge does nothing.
    snapshot();
    FFRDCFG = 1'b0;
    cyc(1);
    RDCFGN = 1'b0;
    cyc(10);
    for (int i = 0; i < NI; i++) chk($sformatf("gated request busy i%0d", i), int'(busy[i]), 0);
    FFRDCFG = 1'b1;
    cyc(5);
    for (int i = 0; i < NI; i++) chk($sformatf("no edge busy i%0d", i), int'(busy[i]), 0);
    chk("gated request bits", cap_n[0] - st_cap[0], 0);
    RDCFGN = 1'b1;
    cyc(2);

    // Abort after five bits
    mem[0] = 8'hA5;
    mem[1] = 8'h3C;
    ready_mode = 0;
    snapshot();
    BASE_ADDR = '0;
    RDCFGN = 1'b0;
    n = 0;
    while (cap_n[0] - st_cap[0] < 5 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("abort reached five bits", int'(n < 200), 1);
    RDCFGN = 1'b1;
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort rdvalid i%0d", i), int'(vld[i]), 0);
      chk($sformatf("abort busy i%0d", i), int'(busy[i]), 0);
      chk($sformatf("abort mem_re i%0d", i), int'(re[i]), 0);
    end
    cyc(20);
    for (int i = 0; i < 3; i++) begin
      int e;
      e = 0;
      for (int k = st_cap[i]; k < cap_n[i]; k++) e += int'(cap_eof[i][k]);
      chk($sformatf("abort done i%0d", i), done_n[i] - st_done[i], 0);
      chk($sformatf("abort eof i%0d", i), e, 0);
    end

    // Reset in mid-frame
    snapshot();
    RDCFGN = 1'b0;
    cyc(8);
    RST = 1'b1;
    #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("midframe reset outputs i%0d", i),
          int'({re[i], maddr[i], dat[i], vld[i], sof[i], eof[i], busy[i], done[i]}), 0);
    cyc(1);
    RDCFGN = 1'b1;
    cyc(1);
    RST = 1'b0;
    cyc(10);
    for (int i = 0; i < 3; i++)
      chk($sformatf("midframe reset done i%0d", i), done_n[i] - st_done[i], 0);
    run_frame("post reset", 4'h0, 1, 1'b0);

    // Randomised frames, including FFRDCFG dropped mid-frame
    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 16; a++) mem[a] = DW'($urandom);
      ready_pct = $urandom_range(20, 100);
      run_frame($sformatf("rand%0d", r), AW'($urandom), 2, bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
